score_display: RTL and testbench
================================

Name: score_display

Overview:
- Multi-digit decimal display driver for the DE1 HEX displays.
- Accepts a binary score through a start/ready handshake and converts it to BCD with an iterative double-dabble shift engine. Then drives NUM_DIGITS active-low 7-segment outputs.
- Sits between game scoring logic and the HEX pins. Replaces per-digit combinational decoding with one registered, parametrised unit that saturates and blanks leading zeros.

Parameters:
- WIDTH, 20: binary input width; one conversion shift per bit.
- NUM_DIGITS, 6: number of HEX digits driven; digit 0 is least significant.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  request conversion; accepted only when start && ready.
- value  input  WIDTH  binary score; sampled on the accepting cycle.
- blank_lz  input  1  leading-zero blanking; sampled with value.
- ready  output  1  high in IDLE.
- done  output  1  one-cycle pulse when the display registers update.
- overflow  output  1  registered; high if the last accepted value > 10^NUM_DIGITS-1.
- hex  output  [NUM_DIGITS] x 7  unpacked array, active-low segments, bit6=g … bit0=a.

Behaviour:
- Reset, asynchronous, while reset_n=0:
  - hex[i]=7'h7F for all i (blank).
  - ready=1, done=0, overflow=0.
  - State=IDLE, shift registers cleared.
- Reset mid-conversion aborts the conversion; the display stays blank until the next completed conversion.
- State IDLE (ready=1):
  - On start, latch value, blank_lz and sat = (value > MAX_VAL), where MAX_VAL = 10^NUM_DIGITS-1.
  - Clear the BCD accumulator (4*NUM_DIGITS bits), load the shift counter with WIDTH, and go to SHIFT.
- State SHIFT (ready=0), one bit per cycle, MSB first:
  - For each BCD nibble ≥5, add 3.
  - Then shift {bcd, bin} left by 1.
  - Decrement the counter; after WIDTH cycles go to COMMIT.
- State COMMIT (1 cycle):
  - Decode nibbles to segments and load the hex registers.
  - overflow<=sat; done=1 this cycle; return to IDLE.
- Latency: start accepted at cycle 0; hex, overflow and done update at the edge ending cycle WIDTH+1. ready returns at cycle WIDTH+2, so back-to-back throughput is one conversion per WIDTH+2 cycles.
- start while ready=0 is ignored and not queued. value/blank_lz changes during a conversion have no effect.
- Saturation: if sat, every digit shows 9, regardless of blank_lz.
- Segment patterns (active-low, 0–9): 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000.
- Nibble >9 cannot occur; the decoder maps it to blank.
- Leading-zero blanking (blank_lz=1):
  - Blank digits above the most significant nonzero digit (7'h7F).
  - Digit 0 is never blanked, so value 0 shows "0".
- hex holds its value between conversions; no combinational path from inputs to hex.

Optional Feature:
- Macro SCORE_DISPLAY_BLINK_EN.
- Defined:
  - Adds input blink (1 bit) and parameter BLINK_DIV (default 25_000_000).
  - A free-running counter toggles a phase bit every BLINK_DIV cycles; counter and phase reset to 0.
  - While blink=1 and phase=1, every hex output is forced to 7'h7F. Stored digits are unaffected.
  - blink=0 shows stored digits immediately on the next cycle.
- Not defined: no blink port, no counter; hex is the stored registers directly.

Decomposition:
- Package score_display_pkg holds:
  - the state enum (IDLE, SHIFT, COMMIT);
  - SEG_BLANK = 7'h7F;
  - the 10-entry digit pattern constant array;
  - a constant function pow10_minus1(n) returning MAX_VAL at elaboration.
- One sub-module, bcd_digit_to_seg: 4-bit nibble plus blank flag in, 7-bit active-low pattern out, purely combinational. Instantiate it NUM_DIGITS times in a generate loop.

Test Plan:
- Reset:
  - Assert reset_n=0 mid-SHIFT → hex all 7'h7F, ready=1, done=0 immediately, with no clock edge needed.
  - After release, a new start converts normally.
- Basic conversion:
  - start with value=123456, blank_lz=0 → done at cycle 21.
  - hex5..hex0 = 1111001, 0100100, 0110000, 0011001, 0010010, 0000010; overflow=0.
- Leading zeros:
  - value=42, blank_lz=1 → hex0=0100100, hex1=0011001, hex2..5=7'h7F.
  - Same value with blank_lz=0 → hex2..5=1000000.
  - value=0, blank_lz=1 → hex0=1000000, rest blank.
- Saturation:
  - value=1000000 → overflow=1, all six digits 0010000.
  - value=999999 → overflow=0, all 9s.
- Handshake:
  - start with value=5, then start with value=7 at cycle 3 → second ignored (ready=0); display shows 5.
  - Exactly one done pulse; ready high at cycle 22.
- Blink (SCORE_DISPLAY_BLINK_EN, BLINK_DIV=4):
  - Digits loaded, blink=1 → hex alternates stored/blank every 4 cycles.
  - blink=0 → stored pattern steady.

Source files
------------

// File: rtl/score_display_pkg.sv
// rtl/score_display_pkg.sv - shared types, segment table and limits for score_display
package score_display_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low segments, bit6=g ... bit0=a, indexed by decimal digit.
  localparam logic [6:0] DIGIT_SEG [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  function automatic logic [63:0] pow10_minus1(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p - 64'd1;
  endfunction

endpackage

// File: rtl/score_display_bcd_digit_to_seg.sv
// rtl/score_display_bcd_digit_to_seg.sv - one BCD nibble to an active-low 7-segment pattern
module bcd_digit_to_seg
  import score_display_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (!blank && nibble <= 4'd9) seg = DIGIT_SEG[nibble];
  end

endmodule

// File: rtl/score_display.sv
// rtl/score_display.sv - binary score to multi-digit HEX display via iterative double-dabble
// Optional blinking of all digits is enabled by defining SCORE_DISPLAY_BLINK_EN.
module score_display
  import score_display_pkg::*;
#(
  parameter int WIDTH      = 20,
  parameter int NUM_DIGITS = 6
`ifdef SCORE_DISPLAY_BLINK_EN
  , parameter int BLINK_DIV = 25_000_000
`endif
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] value,
  input  logic             blank_lz,
`ifdef SCORE_DISPLAY_BLINK_EN
  input  logic             blink,
`endif
  output logic             ready,
  output logic             done,
  output logic             overflow,
  output logic [6:0]       hex [NUM_DIGITS]
);

  localparam int BW = 4 * NUM_DIGITS;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [63:0] MAX_VAL = pow10_minus1(NUM_DIGITS);

  state_t            state, state_n;
  logic [BW-1:0]     bcd, bcd_adj, disp_bcd;
  logic [WIDTH-1:0]  bin;
  logic [CW-1:0]     cnt;
  logic              lz_q, sat_q, seen_nz;
  logic [NUM_DIGITS-1:0] dig_blank;
  logic [6:0]        seg   [NUM_DIGITS];
  logic [6:0]        hex_q [NUM_DIGITS];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = SHIFT;
      SHIFT:   if (cnt == CW'(1)) state_n = COMMIT;
      COMMIT:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    ready = (state == IDLE);
    done  = (state == COMMIT);
  end

  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bcd   <= '0;
      bin   <= '0;
      cnt   <= '0;
      lz_q  <= 1'b0;
      sat_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          bcd   <= '0;
          bin   <= value;
          cnt   <= CW'(WIDTH);
          lz_q  <= blank_lz;
          sat_q <= (64'(value) > MAX_VAL);
        end
        SHIFT: begin
          {bcd, bin} <= {bcd_adj, bin} << 1;
          cnt        <= cnt - CW'(1);
        end
        default: ;
      endcase
    end
  end

  // Saturation overrides both the digits and leading-zero blanking.
  always_comb begin
    disp_bcd  = bcd;
    dig_blank = '0;
    seen_nz   = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      if (sat_q) begin
        disp_bcd[4*i +: 4] = 4'd9;
      end else begin
        seen_nz      = seen_nz | (bcd[4*i +: 4] != 4'd0);
        dig_blank[i] = lz_q && !seen_nz && (i != 0);
      end
    end
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
    bcd_digit_to_seg u_dec (
      .nibble (disp_bcd[4*g +: 4]),
      .blank  (dig_blank[g]),
      .seg    (seg[g])
    );
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_DIGITS; i++) hex_q[i] <= SEG_BLANK;
      overflow <= 1'b0;
    end else if (state == COMMIT) begin
      for (int i = 0; i < NUM_DIGITS; i++) hex_q[i] <= seg[i];
      overflow <= sat_q;
    end
  end

`ifdef SCORE_DISPLAY_BLINK_EN
  localparam int DW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [DW-1:0] div_cnt;
  logic          phase, blank_q;

  // Registered mask keeps the blink input off any combinational path to hex.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt <= '0;
      phase   <= 1'b0;
      blank_q <= 1'b0;
    end else begin
      if (div_cnt == DW'(BLINK_DIV - 1)) begin
        div_cnt <= '0;
        phase   <= ~phase;
      end else begin
        div_cnt <= div_cnt + DW'(1);
      end
      blank_q <= blink && phase;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_DIGITS; i++) hex[i] = blank_q ? SEG_BLANK : hex_q[i];
  end
`else
  always_comb begin
    for (int i = 0; i < NUM_DIGITS; i++) hex[i] = hex_q[i];
  end
`endif

endmodule

// File: tb/tb_score_display.sv
// tb/tb_score_display.sv - randomized self-checking bench for score_display against a decimal model
module tb_score_display;

  localparam int W    = 20;
  localparam int ND   = 6;
  localparam int MAXV = 10**ND - 1;
  localparam logic [6:0] SEG [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  logic         clk = 1'b0;
  logic         reset_n, start, blank_lz;
  logic [W-1:0] value;
  logic         ready, done, overflow;
  logic [6:0]   hex [ND];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  score_display #(.WIDTH(W), .NUM_DIGITS(ND)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .value    (value),
    .blank_lz (blank_lz),
`ifdef SCORE_DISPLAY_BLINK_EN
    .blink    (1'b0),
`endif
    .ready    (ready),
    .done     (done),
    .overflow (overflow),
    .hex      (hex)
  );

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Model: k counts cycles since acceptance; display derived from decimal arithmetic.
  bit         busy;
  int         k, m_val, m_p;
  bit         m_blz;
  logic       m_ovf;
  logic [6:0] m_hex [ND];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy = 0; k = 0; m_ovf = 1'b0;
      for (int i = 0; i < ND; i++) m_hex[i] = 7'h7F;
    end else if (busy) begin
      if (k == W + 1) begin
        busy = 0;
        m_ovf = (m_val > MAXV);
        m_p = 1;
        for (int i = 0; i < ND; i++) begin
          if (m_ovf)                              m_hex[i] = SEG[9];
          else if (m_blz && i > 0 && m_val < m_p) m_hex[i] = 7'h7F;
          else                                    m_hex[i] = SEG[(m_val / m_p) % 10];
          m_p = m_p * 10;
        end
      end else begin
        k++;
      end
    end else if (start) begin
      busy = 1; k = 1; m_val = int'(value); m_blz = blank_lz;
    end
  end

  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      chk("ready", 32'(ready), 32'(!busy));
      chk("done", 32'(done), 32'(busy && k == W + 1));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      for (int i = 0; i < ND; i++) chk($sformatf("hex%0d", i), 32'(hex[i]), 32'(m_hex[i]));
    end
  end

  // Returns one cycle after done, i.e. when the new display and ready are visible.
  task automatic run_conv(input int v, input bit blz, input bit noise, output int lat);
    int n;
    n = 0;
    while (!ready && n < 100) begin @(posedge clk); #1; n++; end
    if (n >= 100) begin checks++; errors++; $display("FAIL ready_wait timeout"); end
    start = 1'b1; value = W'(v); blank_lz = blz;
    @(posedge clk); #1;
    start = 1'b0; value = W'($urandom); blank_lz = 1'($urandom);
    lat = 1;
    while (!done && lat < 100) begin
      @(posedge clk); #1; lat++;
      if (noise) begin
        start = !done && ($urandom_range(0, 3) == 0);
        value = W'($urandom);
      end
    end
    if (lat >= 100) begin checks++; errors++; $display("FAIL done_wait timeout"); end
    start = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int lat, pulses, v;
    reset_n = 1'b0; start = 1'b0; value = '0; blank_lz = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    for (int i = 0; i < ND; i++) chk($sformatf("rst_hex%0d", i), 32'(hex[i]), 32'h7F);
    reset_n = 1'b1;

    run_conv(123456, 1'b0, 1'b0, lat);
    chk("lat_123456", lat, 21);
    chk("ready_cycle22", 32'(ready), 32'd1);
    chk("b_hex5", 32'(hex[5]), 32'b1111001);
    chk("b_hex4", 32'(hex[4]), 32'b0100100);
    chk("b_hex3", 32'(hex[3]), 32'b0110000);
    chk("b_hex2", 32'(hex[2]), 32'b0011001);
    chk("b_hex1", 32'(hex[1]), 32'b0010010);
    chk("b_hex0", 32'(hex[0]), 32'b0000010);
    chk("b_ovf", 32'(overflow), 32'd0);

    run_conv(42, 1'b1, 1'b0, lat);
    chk("lz42_hex0", 32'(hex[0]), 32'b0100100);
    chk("lz42_hex1", 32'(hex[1]), 32'b0011001);
    chk("lz42_hex2", 32'(hex[2]), 32'h7F);
    chk("lz42_hex5", 32'(hex[5]), 32'h7F);

    run_conv(42, 1'b0, 1'b0, lat);
    chk("nz42_hex2", 32'(hex[2]), 32'b1000000);
    chk("nz42_hex5", 32'(hex[5]), 32'b1000000);

    run_conv(0, 1'b1, 1'b0, lat);
    chk("lz0_hex0", 32'(hex[0]), 32'b1000000);
    chk("lz0_hex1", 32'(hex[1]), 32'h7F);

    run_conv(1000000, 1'b1, 1'b0, lat);
    chk("sat_ovf", 32'(overflow), 32'd1);
    chk("sat_hex0", 32'(hex[0]), 32'b0010000);
    chk("sat_hex5", 32'(hex[5]), 32'b0010000);

    // Asynchronous reset in the middle of SHIFT.
    start = 1'b1; value = W'(777777); blank_lz = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_ready", 32'(ready), 32'd1);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_ovf", 32'(overflow), 32'd0);
    for (int i = 0; i < ND; i++) chk($sformatf("mid_rst_hex%0d", i), 32'(hex[i]), 32'h7F);
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    run_conv(31415, 1'b1, 1'b0, lat);
    chk("lat_after_rst", lat, 21);

    run_conv(999999, 1'b1, 1'b0, lat);
    chk("max_ovf", 32'(overflow), 32'd0);
    chk("max_hex5", 32'(hex[5]), 32'b0010000);

    // Second start at cycle 3 must be ignored.
    start = 1'b1; value = W'(5); blank_lz = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    start = 1'b1; value = W'(7);
    @(posedge clk); #1;
    start = 1'b0;
    pulses = 0;
    for (int cyc = 4; cyc < 50; cyc++) begin
      if (done) pulses++;
      if (cyc == 21) chk("hs_done21", 32'(done), 32'd1);
      if (cyc == 22) chk("hs_ready22", 32'(ready), 32'd1);
      @(posedge clk); #1;
    end
    chk("hs_pulses", pulses, 1);
    chk("hs_hex0", 32'(hex[0]), 32'b0010010);
    chk("hs_hex1", 32'(hex[1]), 32'b1000000);

    for (int t = 0; t < 24; t++) begin
      case ($urandom_range(0, 3))
        0:       v = $urandom_range(0, 99);
        1:       v = $urandom_range(0, MAXV);
        2:       v = $urandom_range(MAXV - 5, MAXV + 5);
        default: v = $urandom_range(0, (1 << W) - 1);
      endcase
      run_conv(v, 1'($urandom_range(0, 1)), 1'b1, lat);
      chk("rand_lat", lat, 21);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
